// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte producers.
// Each accepted byte becomes one frame: start pulse, wait for busy to rise, then wait for busy to fall.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 3,
   parameter int BUSY_TIMEOUT = 16,
   parameter int CNT_W        = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   i_req_valid,
   input  logic [8*NUM_REQ-1:0] i_req_data,
   output logic [NUM_REQ-1:0]   o_req_ready,
   output logic [7:0]           o_tx_data,
   output logic                 o_tx_start,
   input  logic                 i_tx_busy,
   output logic [2:0]           o_grant_id,
   output logic                 o_active,
   output logic                 o_timeout
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      START     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] pick;
   logic             pick_ok;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic             cnt_done;

   // Search rr_ptr+1, rr_ptr+2, ... so the last grantee has the lowest priority.
   always_comb begin
      int sum;
      logic [PTR_W-1:0] idx;
      pick    = rr_ptr;
      pick_ok = 1'b0;
      sum     = 0;
      idx     = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         sum = int'(rr_ptr) + i;
         if (sum >= NUM_REQ) sum = sum - NUM_REQ;
         idx = PTR_W'(sum);
         if (i_req_valid[idx]) begin
            pick    = idx;
            pick_ok = 1'b1;
         end
      end
   end

   assign accept   = (state == IDLE) && !i_tx_busy && pick_ok && !reset;
   assign cnt_done = (cnt == CNT_W'(BUSY_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (accept) state_nxt = START;
         START:     state_nxt = WAIT_BUSY;
         WAIT_BUSY: begin
            if (i_tx_busy)     state_nxt = WAIT_DONE;
            else if (cnt_done) state_nxt = IDLE;
         end
         WAIT_DONE: if (!i_tx_busy) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      o_req_ready = '0;
      if (accept) o_req_ready[pick] = 1'b1;
      o_tx_start = (state == START);
   end

   // Byte and grant id are only rewritten on accept, so they hold steady for the whole frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         o_tx_data  <= 8'h00;
         o_grant_id <= 3'd0;
         o_active   <= 1'b0;
         o_timeout  <= 1'b0;
         rr_ptr     <= PTR_W'(NUM_REQ - 1);
         cnt        <= '0;
      end else begin
         o_timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  o_tx_data  <= i_req_data[int'(pick)*8 +: 8];
                  o_grant_id <= 3'(pick);
                  rr_ptr     <= pick;
                  o_active   <= 1'b1;
               end
            end
            START: cnt <= '0;
            WAIT_BUSY: begin
               if (!i_tx_busy) begin
                  cnt <= cnt + 1'b1;
                  if (cnt_done) begin
                     o_timeout <= 1'b1;
                     o_active  <= 1'b0;
                  end
               end
            end
            WAIT_DONE: if (!i_tx_busy) o_active <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule
